// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings for the MEM pipeline stage.
// Holds access-size codes, FSM state codes, the op bundle and an alignment check.
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [1:0] ST_IDLE   = 2'b00;
   localparam logic [1:0] ST_ACCESS = 2'b01;
   localparam logic [1:0] ST_HOLD   = 2'b10;

   typedef struct packed {
      logic       ld;
      logic       st;
      logic [1:0] size;
      logic       sgn;
   } mem_op_t;

   // Size 11 behaves as a word access.
   function automatic logic misaligned(input logic [1:0] size,
                                       input logic [1:0] lo);
      logic m;
      unique case (1'b1)
         (size == SZ_BYTE): m = 1'b0;
         (size == SZ_HALF): m = lo[0];
         default:           m = (lo != 2'b00);
      endcase
      return m;
   endfunction

endpackage

// File: rtl/mem_align.sv
// mem_align: byte-lane steering for stores and lane extraction for loads.
// Ports: size_i/sign_i/addr_i (low addr bits), b_i store data, rdata_i read word;
// we_o byte strobes, wdata_o replicated store data, ldata_o extended load value.
module mem_align
   import mem_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic        sign_i,
   input  logic [1:0]  addr_i,
   input  logic [31:0] b_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  we_o,
   output logic [31:0] wdata_o,
   output logic [31:0] ldata_o
);

   logic [31:0] lane;

   // Shift the addressed lane down to bit 0.
   assign lane = rdata_i >> {addr_i, 3'b000};

   always_comb begin
      we_o    = 4'b1111;
      wdata_o = b_i;
      ldata_o = lane;
      unique case (1'b1)
         (size_i == SZ_BYTE): begin
            we_o    = 4'b0001 << addr_i;
            wdata_o = {4{b_i[7:0]}};
            ldata_o = {{24{sign_i & lane[7]}}, lane[7:0]};
         end
         (size_i == SZ_HALF): begin
            we_o    = 4'b0011 << addr_i;
            wdata_o = {2{b_i[15:0]}};
            ldata_o = {{16{sign_i & lane[15]}}, lane[15:0]};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_seg_param.sv
// mem_seg_param: MEM stage with valid/ready handshake and fixed-latency memory.
// Ports: in_* upstream EX bundle, mem_* memory port, out_*/lmd/ir_out/misalign to WB.
module mem_seg_param
   import mem_pkg::*;
#(
   parameter int ADDR_W  = 14,
   parameter int MEM_LAT = 3,
   parameter int DATA_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] b_i,
   input  logic [DATA_W-1:0] aluo_i,
   input  logic [31:0]       ir_i,
   input  logic              is_load,
   input  logic              is_store,
   input  logic [1:0]        size_i,
   input  logic              sign_i,
   output logic              mem_en,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] aluo_out,
   output logic [DATA_W-1:0] lmd,
   output logic [31:0]       ir_out,
   output logic              misalign
);

   if (DATA_W != 32) begin : g_bad_dw
      $error("mem_seg_param: DATA_W must be 32");
   end
   if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
      $error("mem_seg_param: MEM_LAT must be 1..15");
   end

   localparam logic [3:0] LAST = 4'(MEM_LAT - 1);

   logic [1:0]        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   mem_op_t           op_q, op_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [DATA_W-1:0] aluo_q, aluo_d;
   logic [DATA_W-1:0] lmd_q, lmd_d;
   logic [31:0]       ir_q, ir_d;
   logic              mis_q, mis_d;

   logic        accept, last, in_mem, in_mis;
   logic [3:0]  we_w;
   logic [31:0] wdata_w, ldata_w;

   mem_align u_align (
      .size_i  (op_q.size),
      .sign_i  (op_q.sgn),
      .addr_i  (aluo_q[1:0]),
      .b_i     (b_q),
      .rdata_i (mem_rdata),
      .we_o    (we_w),
      .wdata_o (wdata_w),
      .ldata_o (ldata_w)
   );

   assign in_ready = (state_q == ST_IDLE)
                   | ((state_q == ST_HOLD) & out_ready);
   assign accept   = in_valid & in_ready;
   assign last     = (state_q == ST_ACCESS) & (cnt_q == LAST);
   assign in_mem   = is_load | is_store;
   assign in_mis   = in_mem & misaligned(size_i, aluo_i[1:0]);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      b_d     = b_q;
      aluo_d  = aluo_q;
      ir_d    = ir_q;
      mis_d   = mis_q;
      lmd_d   = lmd_q;
      unique case (1'b1)
         accept: begin
            // Store wins when both class bits are set.
            op_d.ld   = is_load & ~is_store;
            op_d.st   = is_store;
            op_d.size = size_i;
            op_d.sgn  = sign_i;
            b_d       = b_i;
            aluo_d    = aluo_i;
            ir_d      = ir_i;
            mis_d     = in_mis;
            lmd_d     = '0;
            cnt_d     = '0;
            state_d   = (in_mem & ~in_mis) ? ST_ACCESS : ST_HOLD;
         end
         last: begin
            state_d = ST_HOLD;
            if (op_q.ld) lmd_d = ldata_w;
         end
         ((state_q == ST_ACCESS) & (cnt_q != LAST)): begin
            cnt_d = cnt_q + 4'd1;
         end
         ((state_q == ST_HOLD) & out_ready & ~in_valid): begin
            state_d = ST_IDLE;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         b_q     <= '0;
         aluo_q  <= '0;
         ir_q    <= '0;
         mis_q   <= 1'b0;
         lmd_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         b_q     <= b_d;
         aluo_q  <= aluo_d;
         ir_q    <= ir_d;
         mis_q   <= mis_d;
         lmd_q   <= lmd_d;
      end
   end

   // Strobes only on the final access cycle, so a reset mid-access
   // can never leave a partial write behind.
   assign mem_en    = (state_q == ST_ACCESS);
   assign mem_we    = (last & op_q.st) ? we_w : 4'b0000;
   assign mem_addr  = aluo_q[ADDR_W+1:2];
   assign mem_wdata = wdata_w;
   assign out_valid = (state_q == ST_HOLD);
   assign aluo_out  = aluo_q;
   assign lmd       = lmd_q;
   assign ir_out    = ir_q;
   assign misalign  = mis_q;

endmodule

// File: doc/mem_seg_param.md
MEM_SEG_PARAM -- requirements
Module: mem_seg_param

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 14, word-address width presented to memory.
REQ-002 The module SHALL have parameter MEM_LAT, default 3, memory access cycles per load/store (legal range 1..15).
REQ-003 The module SHALL have parameter DATA_W, default 32, datapath width (only 32 is supported; elaboration SHALL fail otherwise).
REQ-004 The module SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 The module SHALL have port in_valid, input, 1, upstream EX result valid.
REQ-007 The module SHALL have port in_ready, output, 1, the stage accepts this cycle.
REQ-008 The module SHALL have port b_i, input, DATA_W, store data.
REQ-009 The module SHALL have port aluo_i, input, DATA_W, ALU result / byte address.
REQ-010 The module SHALL have port ir_i, input, 32, instruction word passed through.
REQ-011 The module SHALL have ports is_load, input, 1 and is_store, input, 1, operation class (both high is treated as store).
REQ-012 The module SHALL have port size_i, input, 2, access size: 00 byte, 01 half, 10 word, 11 treated as word.
REQ-013 The module SHALL have port sign_i, input, 1, sign-extend loads when high.
REQ-014 The module SHALL have ports mem_en, output, 1; mem_we, output, 4 (byte strobes); mem_addr, output, ADDR_W; mem_wdata, output, DATA_W; mem_rdata, input, DATA_W.
REQ-015 The module SHALL have ports out_valid, output, 1; out_ready, input, 1; aluo_out, output, DATA_W; lmd, output, DATA_W; ir_out, output, 32; misalign, output, 1.

Function
REQ-016 The FSM SHALL have states IDLE, ACCESS and HOLD; in_ready = (IDLE) or (HOLD and out_ready).
REQ-017 A transfer is accepted when in_valid and in_ready are both high; b_i, aluo_i, ir_i, op class, size and sign are registered on acceptance.
REQ-018 An accepted non-memory operation (neither load nor store) or a misaligned access SHALL go directly to HOLD, giving out_valid one cycle after acceptance.
REQ-019 Misaligned means half with addr[0]=1, or word with addr[1:0]!=0; it SHALL raise misalign with the result, perform no memory access, and set lmd=0.
REQ-020 An aligned load/store SHALL enter ACCESS with a cycle counter cnt=0, hold mem_en high for MEM_LAT cycles, and proceed to HOLD after cnt=MEM_LAT-1; out_valid rises MEM_LAT+1 cycles after acceptance.
REQ-021 mem_addr SHALL be registered aluo[ADDR_W+1:2] throughout ACCESS; mem_we SHALL be nonzero only on the cycle cnt=MEM_LAT-1 of a store.
REQ-022 Byte strobes: byte = 0001 shifted left by addr[1:0]; half = 0011 shifted left by addr[1:0]; word = 1111.
REQ-023 mem_wdata: byte = b[7:0] replicated x4; half = b[15:0] replicated x2; word = b.
REQ-024 For a load, mem_rdata SHALL be sampled at cnt=MEM_LAT-1, the addressed lane extracted, and the result zero- or sign-extended per sign_i into lmd; stores and non-memory ops SHALL give lmd=0.
REQ-025 In HOLD, outputs SHALL stay stable until out_ready; HOLD with out_ready and in_valid SHALL retire the held result and accept the new one in the same cycle (no bubble).
REQ-026 HOLD with out_ready and no in_valid SHALL return to IDLE and drop out_valid.
REQ-027 in_ready SHALL be low throughout ACCESS; upstream stalls.

Reset
REQ-028 Asserting rst low SHALL immediately force IDLE, cnt=0, out_valid=0, mem_en=0, mem_we=0, misalign=0, and all data registers to 0, including during ACCESS (write aborted, no partial strobe).
REQ-029 After rst deasserts, the first acceptance SHALL be possible on the first rising clk edge.

Structure
REQ-030 The size encodings (BYTE/HALF/WORD) and the FSM state encoding SHALL be defined in shared package mem_pkg.
REQ-031 Lane extraction/extension and strobe/replication logic SHALL live in one combinational sub-module mem_align; the FSM, counter and registers stay in mem_seg_param.

Verification
REQ-032 ALU op, aluo_i=0x00001234, out_ready=1 -> out_valid after 1 cycle, aluo_out=0x00001234, lmd=0, mem_en never high.
REQ-033 Store byte, addr=0x00000006, b_i=0x000000AB, MEM_LAT=3 -> mem_en high 3 cycles, mem_addr=1, mem_we=0100 only on the 3rd cycle, mem_wdata=0xABABABAB.
REQ-034 Load half signed, addr=0x00000002, mem_rdata=0x80010000 -> lmd=0xFFFF8001; same access unsigned -> lmd=0x00008001; out_valid at cycle 4.
REQ-035 Load word, addr=0x00000001 -> misalign=1, lmd=0, mem_en never high, out_valid after 1 cycle.
REQ-036 Result held with out_ready=0 for 5 cycles -> outputs stable and in_ready=0; then out_ready=1 with in_valid=1 -> new op accepted in the same cycle.
REQ-037 rst low at cnt=1 of a store -> mem_we never nonzero, out_valid=0, FSM in IDLE on release.
